// File: rtl/bc_pkg.sv
// bc_pkg: shared encodings for the basic-computer sequence controller
// (bus sources, ALU ops, control-strobe bit positions, opcodes, T states).
package bc_pkg;

  localparam int unsigned CTRL_W = 21;

  typedef enum logic [2:0] {
    BUS_NONE = 3'b000,
    BUS_PC   = 3'b001,
    BUS_AR   = 3'b010,
    BUS_AC   = 3'b011,
    BUS_IR   = 3'b100,
    BUS_DR   = 3'b101,
    BUS_MEM  = 3'b110,
    BUS_TR   = 3'b111
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_DR   = 3'b010,
    ALU_CMA  = 3'b011,
    ALU_CIR  = 3'b100,
    ALU_CIL  = 3'b101,
    ALU_INPR = 3'b110,
    ALU_NOP  = 3'b111
  } alu_sel_e;

  typedef enum logic [4:0] {
    C_AR_LD   = 5'd0,
    C_AR_INR  = 5'd1,
    C_AR_CLR  = 5'd2,
    C_PC_LD   = 5'd3,
    C_PC_INR  = 5'd4,
    C_PC_CLR  = 5'd5,
    C_DR_LD   = 5'd6,
    C_DR_INR  = 5'd7,
    C_DR_CLR  = 5'd8,
    C_AC_LD   = 5'd9,
    C_AC_INR  = 5'd10,
    C_AC_CLR  = 5'd11,
    C_IR_LD   = 5'd12,
    C_TR_LD   = 5'd13,
    C_TR_INR  = 5'd14,
    C_TR_CLR  = 5'd15,
    C_MEM_WR  = 5'd16,
    C_E_LD    = 5'd17,
    C_E_CMP   = 5'd18,
    C_E_CLR   = 5'd19,
    C_OUTR_LD = 5'd20
  } ctrl_bit_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
  } t_state_e;

  // Opcode field -> one-hot D0..D7.
  function automatic logic [7:0] dec_onehot(input logic [2:0] op);
    return 8'b1 << op;
  endfunction

endpackage

// File: rtl/bc_seq_controller_if.sv
// bc_seq_controller_if: controller <-> datapath signal bundle.
// FGI/FGO are present only when BC_INTR_EN is defined.
interface bc_seq_controller_if
  import bc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SC_W  = 3
);

`ifdef BC_INTR_EN
  logic              FGI;
  logic              FGO;
`endif
  logic [WIDTH-1:0]  IR;
  logic              CO;
  logic              Z;
  logic              N;
  logic              OVF;
  logic              E_IN;
  logic              DR_Z;
  logic [2:0]        BUS_SEL;
  logic [CTRL_W-1:0] CTRL;
  logic [2:0]        ALU_SEL;
  logic [SC_W-1:0]   T_STATE;
  logic              HALT;

  modport master (
`ifdef BC_INTR_EN
    input  FGI, FGO,
`endif
    input  IR, CO, Z, N, OVF, E_IN, DR_Z,
    output BUS_SEL, CTRL, ALU_SEL, T_STATE, HALT
  );

  modport slave (
`ifdef BC_INTR_EN
    output FGI, FGO,
`endif
    output IR, CO, Z, N, OVF, E_IN, DR_Z,
    input  BUS_SEL, CTRL, ALU_SEL, T_STATE, HALT
  );

endinterface

// File: rtl/bc_seq_counter.sv
// bc_seq_counter: sequence counter with clear/increment/hold and one-hot T decode.
module bc_seq_counter #(
  parameter int unsigned SC_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inr,
  output logic [SC_W-1:0]        sc,
  output logic [(2**SC_W)-1:0]   t_onehot
);

  logic [SC_W-1:0] sc_q, sc_d;

  // Next count: clear beats increment; neither asserted holds.
  always_comb begin
    sc_d = sc_q;
    if (clr)      sc_d = '0;
    else if (inr) sc_d = sc_q + SC_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sc_q <= '0;
    else     sc_q <= sc_d;
  end

  // One-hot decode of the current count.
  always_comb begin
    t_onehot       = '0;
    t_onehot[sc_q] = 1'b1;
  end

  assign sc = sc_q;

endmodule

// File: rtl/bc_seq_controller.sv
// bc_seq_controller: hardwired controller for the basic computer.
// Owns SC, latched decode D0..D7, I and S; drives bus select, strobes, ALU op.
// Optional interrupt / I/O support is enabled with the BC_INTR_EN macro.
module bc_seq_controller
  import bc_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned SC_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bc_seq_controller_if.master  bus
);

  logic [WIDTH-1:0]      ir;
  logic [SC_W-1:0]       sc;
  logic [(2**SC_W)-1:0]  t;
  logic                  sc_clr, sc_inr, clr_req, active;
  logic                  s_q, s_d, i_q, i_d, live_q, live_d;
  logic [7:0]            d_q, d_d;
  bus_sel_e              bus_sel;
  alu_sel_e              alu_sel;
  logic [CTRL_W-1:0]     ctrl;
  logic                  irq_cyc;
  logic                  unused_sigs;

`ifdef BC_INTR_EN
  logic ien_q, ien_d, r_q, r_d;
  assign irq_cyc = r_q & (t[T0] | t[T1] | t[T2]);
`else
  assign irq_cyc = 1'b0;
`endif

  assign ir = bus.IR;

  // live_q is low while reset is held and for the cycle after release, so the
  // controller idles there and T0 work begins on the first edge after release.
  assign active = live_q & s_q;
  assign sc_clr = active & clr_req;
  assign sc_inr = active & ~clr_req;

  bc_seq_counter #(.SC_W(SC_W)) u_sc (
    .clk      (clk),
    .rst      (rst),
    .clr      (sc_clr),
    .inr      (sc_inr),
    .sc       (sc),
    .t_onehot (t)
  );

  // Control decode: strobes, bus source, ALU op, SC clear and next flag state.
  always_comb begin
    bus_sel = BUS_NONE;
    alu_sel = ALU_NOP;
    ctrl    = '0;
    clr_req = 1'b0;
    s_d     = s_q;
    i_d     = i_q;
    d_d     = d_q;
    live_d  = 1'b1;
`ifdef BC_INTR_EN
    ien_d   = ien_q;
    r_d     = r_q;
`endif
    if (active) begin
      if (irq_cyc) begin
`ifdef BC_INTR_EN
        if (t[T0]) begin
          ctrl[C_AR_CLR] = 1'b1;
          bus_sel        = BUS_PC;
          ctrl[C_TR_LD]  = 1'b1;
        end else if (t[T1]) begin
          bus_sel        = BUS_TR;
          ctrl[C_MEM_WR] = 1'b1;
          ctrl[C_PC_CLR] = 1'b1;
        end else begin
          ctrl[C_PC_INR] = 1'b1;
          ien_d          = 1'b0;
          r_d            = 1'b0;
          clr_req        = 1'b1;
        end
`endif
      end else if (t[T0]) begin
        bus_sel       = BUS_PC;
        ctrl[C_AR_LD] = 1'b1;
      end else if (t[T1]) begin
        bus_sel        = BUS_MEM;
        ctrl[C_IR_LD]  = 1'b1;
        ctrl[C_PC_INR] = 1'b1;
      end else if (t[T2]) begin
        bus_sel       = BUS_IR;
        ctrl[C_AR_LD] = 1'b1;
        d_d           = dec_onehot(ir[ADDR_W+2:ADDR_W]);
        i_d           = ir[ADDR_W+3];
      end else if (t[T3]) begin
        if (!d_q[OP_REG]) begin
          if (i_q) begin
            bus_sel       = BUS_MEM;
            ctrl[C_AR_LD] = 1'b1;
          end
        end else if (!i_q) begin
          clr_req = 1'b1;
          if      (ir[11]) ctrl[C_AC_CLR] = 1'b1;
          else if (ir[10]) ctrl[C_E_CLR]  = 1'b1;
          else if (ir[9]) begin
            ctrl[C_AC_LD] = 1'b1;
            alu_sel       = ALU_CMA;
          end
          else if (ir[8])  ctrl[C_E_CMP]  = 1'b1;
          else if (ir[7]) begin
            ctrl[C_AC_LD] = 1'b1;
            alu_sel       = ALU_CIR;
          end
          else if (ir[6]) begin
            ctrl[C_AC_LD] = 1'b1;
            alu_sel       = ALU_CIL;
          end
          else if (ir[5])  ctrl[C_AC_INR] = 1'b1;
          else if (ir[4])  ctrl[C_PC_INR] = ~bus.N;
          else if (ir[3])  ctrl[C_PC_INR] = bus.N;
          else if (ir[2])  ctrl[C_PC_INR] = bus.Z;
          else if (ir[1])  ctrl[C_PC_INR] = ~bus.E_IN;
          else if (ir[0])  s_d            = 1'b0;
        end else begin
          clr_req = 1'b1;
`ifdef BC_INTR_EN
          if (ir[11]) begin
            ctrl[C_AC_LD] = 1'b1;
            alu_sel       = ALU_INPR;
          end
          else if (ir[10]) begin
            bus_sel         = BUS_AC;
            ctrl[C_OUTR_LD] = 1'b1;
          end
          else if (ir[9])  ctrl[C_PC_INR] = bus.FGI;
          else if (ir[8])  ctrl[C_PC_INR] = bus.FGO;
          else if (ir[7])  ien_d          = 1'b1;
          else if (ir[6])  ien_d          = 1'b0;
`endif
        end
      end else if (t[T4] && (d_q[OP_AND] || d_q[OP_ADD] || d_q[OP_LDA] || d_q[OP_ISZ])) begin
        bus_sel       = BUS_MEM;
        ctrl[C_DR_LD] = 1'b1;
      end else if (t[T4] && d_q[OP_STA]) begin
        bus_sel        = BUS_AC;
        ctrl[C_MEM_WR] = 1'b1;
        clr_req        = 1'b1;
      end else if (t[T4] && d_q[OP_BUN]) begin
        bus_sel       = BUS_AR;
        ctrl[C_PC_LD] = 1'b1;
        clr_req       = 1'b1;
      end else if (t[T4] && d_q[OP_BSA]) begin
        bus_sel        = BUS_PC;
        ctrl[C_MEM_WR] = 1'b1;
        ctrl[C_AR_INR] = 1'b1;
      end else if (t[T5] && d_q[OP_AND]) begin
        ctrl[C_AC_LD] = 1'b1;
        alu_sel       = ALU_AND;
        clr_req       = 1'b1;
      end else if (t[T5] && d_q[OP_ADD]) begin
        ctrl[C_AC_LD] = 1'b1;
        ctrl[C_E_LD]  = 1'b1;
        alu_sel       = ALU_ADD;
        clr_req       = 1'b1;
      end else if (t[T5] && d_q[OP_LDA]) begin
        ctrl[C_AC_LD] = 1'b1;
        alu_sel       = ALU_DR;
        clr_req       = 1'b1;
      end else if (t[T5] && d_q[OP_BSA]) begin
        bus_sel       = BUS_AR;
        ctrl[C_PC_LD] = 1'b1;
        clr_req       = 1'b1;
      end else if (t[T5] && d_q[OP_ISZ]) begin
        ctrl[C_DR_INR] = 1'b1;
      end else if (t[T6] && d_q[OP_ISZ]) begin
        bus_sel        = BUS_DR;
        ctrl[C_MEM_WR] = 1'b1;
        ctrl[C_PC_INR] = bus.DR_Z;
        clr_req        = 1'b1;
      end else begin
        // Unreachable (T,D) pair: return to T0 so SC never wraps past T6.
        clr_req = 1'b1;
      end
`ifdef BC_INTR_EN
      if (!(t[T0] || t[T1] || t[T2]) && ien_q && (bus.FGI || bus.FGO))
        r_d = 1'b1;
`endif
    end
  end

  // Controller flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b1;
      i_q    <= 1'b0;
      d_q    <= '0;
      live_q <= 1'b0;
`ifdef BC_INTR_EN
      ien_q  <= 1'b0;
      r_q    <= 1'b0;
`endif
    end else begin
      s_q    <= s_d;
      i_q    <= i_d;
      d_q    <= d_d;
      live_q <= live_d;
`ifdef BC_INTR_EN
      ien_q  <= ien_d;
      r_q    <= r_d;
`endif
    end
  end

  assign bus.BUS_SEL = bus_sel;
  assign bus.CTRL    = ctrl;
  assign bus.ALU_SEL = alu_sel;
  assign bus.T_STATE = sc;
  assign bus.HALT    = ~s_q;

  // CO feeds E directly in the datapath and OVF is observe-only.
  assign unused_sigs = ^{bus.CO, bus.OVF, ir, t};

endmodule
